// File: rtl/bip_pkg.sv
// Shared definitions for the BIP fetch stage and decoder: opcodes, fetch-state encoding, default widths.
package bip_pkg;
  localparam int PC_BITS_DEF   = 11;
  localparam int INST_BITS_DEF = 16;
  localparam int OPBTS_DEF     = 5;
  localparam int CNT_BITS_DEF  = 16;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/bip_pc_reg.sv
// Program counter register: clear has priority over increment; otherwise holds.
module bip_pc_reg #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_pc
);
  logic [W-1:0] r_pc;

  // Increment wraps naturally modulo 2^W.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/bip_fetch_unit.sv
// Fetch/sequencing stage: PC, program-memory read, IR and FETCH/LOAD/EXEC control.
// Each instruction takes three cycles; the halt flag wins over the PC write in EXEC.
module bip_fetch_unit
  import bip_pkg::*;
#(
  parameter int PC_BITS   = PC_BITS_DEF,
  parameter int INST_BITS = INST_BITS_DEF,
  parameter int OPBTS     = OPBTS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_w_pc,
  input  logic                       i_h_flg,
  input  logic [INST_BITS-1:0]       i_imem_data,
  output logic [PC_BITS-1:0]         o_imem_addr,
  output logic                       o_imem_en,
  output logic [OPBTS-1:0]           o_op_code,
  output logic [INST_BITS-OPBTS-1:0] o_operand,
  output logic                       o_valid,
  output logic [PC_BITS-1:0]         o_pc,
  output logic                       o_halted,
  output logic [CNT_BITS-1:0]        o_icount
);
  fetch_state_t         r_state;
  logic [INST_BITS-1:0] r_ir;
  logic [CNT_BITS-1:0]  r_icount;
  logic                 r_valid;
  logic                 r_imem_en;
  logic                 r_halted;
  logic                 w_start_ok;
  logic                 w_pc_inc;
  logic [PC_BITS-1:0]   w_pc;

  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_HALT));
  assign w_pc_inc   = (r_state == S_EXEC) && !i_h_flg && i_w_pc;

  bip_pc_reg #(.W(PC_BITS)) u_pc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_start_ok),
    .i_inc   (w_pc_inc),
    .o_pc    (w_pc)
  );

  // Outputs are registered alongside the state so they reflect the state being entered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_icount  <= '0;
      r_valid   <= 1'b0;
      r_imem_en <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_imem_en <= 1'b0;
      r_halted  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_FETCH;
            r_icount  <= '0;
            r_imem_en <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_ir    <= i_imem_data;
          r_state <= S_EXEC;
          r_valid <= 1'b1;
        end
        S_EXEC: begin
          if (r_icount != {CNT_BITS{1'b1}}) r_icount <= r_icount + 1'b1;
          if (i_h_flg) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state   <= S_FETCH;
            r_imem_en <= 1'b1;
          end
        end
        S_HALT: begin
          if (i_start) begin
            r_state   <= S_FETCH;
            r_icount  <= '0;
            r_imem_en <= 1'b1;
          end else begin
            r_halted <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fields read as zero (HLT) outside EXEC so downstream writes stay inert.
  assign o_op_code   = r_valid ? r_ir[INST_BITS-1 -: OPBTS] : '0;
  assign o_operand   = r_valid ? r_ir[INST_BITS-OPBTS-1:0] : '0;
  assign o_valid     = r_valid;
  assign o_imem_en   = r_imem_en;
  assign o_imem_addr = w_pc;
  assign o_pc        = w_pc;
  assign o_halted    = r_halted;
  assign o_icount    = r_icount;
endmodule
